// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM state encoding and the clocks-per-bit helper
// used by both the transmit writer and the receive path.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_t;

    // Clocks per bit; integer division, so the bit period is truncated, never rounded up.
    function automatic int unsigned uart_scale(input int unsigned clk_mhz,
                                               input int unsigned boadrate);
        return (clk_mhz * 32'd1_000_000) / boadrate;
    endfunction

endpackage

// File: rtl/uart_rx_reader.sv
// Serial byte reader: synchronizes rx, detects the start edge, samples each 8N1 bit
// at its centre and emits one strobe per good byte or one frame_err per bad stop bit.
module uart_rx_reader
    import uart_pkg::*;
#(
    parameter int unsigned SCALE = 5208
) (
    input  logic       clk,
    input  logic       arstn,
    input  logic       rx,
    output logic [7:0] rx_byte,
    output logic       byte_strobe,
    output logic       frame_err
);

    localparam logic [31:0] HALF_RELOAD = 32'(SCALE / 2 - 1);
    localparam logic [31:0] FULL_RELOAD = 32'(SCALE - 1);

    logic        rx_m;
    logic        rx_s;
    logic        rx_s_d;
    rx_state_t   state;
    logic [31:0] cnt;
    logic        tick;
    logic [2:0]  bit_idx;
    logic [7:0]  shift_reg;

    // Two-stage synchronizer plus one delay stage for edge detection; all idle-high.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            rx_m   <= 1'b1;
            rx_s   <= 1'b1;
            rx_s_d <= 1'b1;
        end else begin
            rx_m   <= rx;
            rx_s   <= rx_m;
            rx_s_d <= rx_s;
        end
    end

    assign tick = (cnt == 32'd0);

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            state       <= IDLE;
            cnt         <= 32'd0;
            bit_idx     <= 3'd0;
            shift_reg   <= 8'd0;
            rx_byte     <= 8'd0;
            byte_strobe <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            byte_strobe <= 1'b0;
            frame_err   <= 1'b0;
            case (state)
                IDLE: begin
                    // Only a high-to-low transition starts a frame, so a held break is ignored.
                    if (rx_s_d && !rx_s) begin
                        state <= START;
                        cnt   <= HALF_RELOAD;
                    end
                end
                START: begin
                    if (tick) begin
                        if (!rx_s) begin
                            state   <= DATA;
                            cnt     <= FULL_RELOAD;
                            bit_idx <= 3'd0;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        cnt <= cnt - 32'd1;
                    end
                end
                DATA: begin
                    if (tick) begin
                        shift_reg <= {rx_s, shift_reg[7:1]};
                        bit_idx   <= bit_idx + 3'd1;
                        cnt       <= FULL_RELOAD;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end
                    end else begin
                        cnt <= cnt - 32'd1;
                    end
                end
                STOP: begin
                    if (tick) begin
                        if (rx_s) begin
                            byte_strobe <= 1'b1;
                            rx_byte     <= shift_reg;
                        end else begin
                            frame_err <= 1'b1;
                        end
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - 32'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receive top: reads 8N1 bytes and packs DEPTH of them, first byte in slot 0,
// into a word offered on a valid/ready interface; reports overruns of the pending word.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned clk_mhz  = 50,
    parameter int unsigned boadrate = 9600
) (
    input  logic                  clk,
    input  logic                  arstn,
    input  logic                  rx,
    output logic                  down_valid,
    input  logic                  down_ready,
    output logic [DEPTH-1:0][7:0] data_o,
    output logic                  frame_err,
    output logic                  overrun
);

    localparam int unsigned SCALE = uart_scale(clk_mhz, boadrate);
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    logic [7:0]       rx_byte;
    logic             byte_strobe;
    logic [IDX_W-1:0] wr_idx;
    logic             slot_free;

    uart_rx_reader #(
        .SCALE(SCALE)
    ) u_reader (
        .clk        (clk),
        .arstn      (arstn),
        .rx         (rx),
        .rx_byte    (rx_byte),
        .byte_strobe(byte_strobe),
        .frame_err  (frame_err)
    );

    // A completed word leaves wr_idx at 0, so a byte arriving in the handshake
    // cycle naturally lands in slot 0 of the next word.
    assign slot_free = !down_valid || down_ready;

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            down_valid <= 1'b0;
            overrun    <= 1'b0;
            data_o     <= '0;
            wr_idx     <= '0;
        end else begin
            overrun <= 1'b0;
            if (down_valid && down_ready) begin
                down_valid <= 1'b0;
            end
            if (byte_strobe) begin
                if (slot_free) begin
                    data_o[wr_idx] <= rx_byte;
                    if (wr_idx == LAST_IDX) begin
                        down_valid <= 1'b1;
                        wr_idx     <= '0;
                    end else begin
                        wr_idx <= wr_idx + 1'b1;
                    end
                end else begin
                    overrun <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx at SCALE=10, DEPTH=4: a behavioural 8N1 transmitter drives rx and
// expected words are built from the bytes sent, first byte in the lowest slot.
module tb_uart_rx;
    import uart_pkg::*;

    localparam int DEPTH = 4;
    localparam int SCALE = 10;

    logic                  clk = 1'b0;
    logic                  arstn = 1'b0;
    logic                  rx = 1'b1;
    logic                  down_ready = 1'b0;
    logic                  down_valid;
    logic                  frame_err;
    logic                  overrun;
    logic [DEPTH-1:0][7:0] data_o;

    int checks = 0;
    int failures = 0;
    int fe_cnt = 0;
    int ov_cnt = 0;
    int sb_cnt = 0;

    always #10 clk = ~clk;

    uart_rx #(
        .DEPTH   (DEPTH),
        .clk_mhz (50),
        .boadrate(5_000_000)
    ) dut (
        .clk       (clk),
        .arstn     (arstn),
        .rx        (rx),
        .down_valid(down_valid),
        .down_ready(down_ready),
        .data_o    (data_o),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always @(negedge clk) begin
        if (frame_err) fe_cnt++;
        if (overrun) ov_cnt++;
        if (dut.byte_strobe) sb_cnt++;
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] pack4(input logic [7:0] b0, input logic [7:0] b1,
                                          input logic [7:0] b2, input logic [7:0] b3);
        return {b3, b2, b1, b0};
    endfunction

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        @(negedge clk);
        rx = 1'b0;
        repeat (SCALE) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (SCALE) @(negedge clk);
        end
        rx = stop_bit;
        repeat (SCALE) @(negedge clk);
        rx = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic accept_word();
        down_ready = 1'b1;
        @(negedge clk);
        down_ready = 1'b0;
    endtask

    task automatic test_reset();
        arstn = 1'b0;
        rx = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (down_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", down_valid); end
        checks++;
        if (frame_err !== 1'b0) begin failures++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
        checks++;
        if (overrun !== 1'b0) begin failures++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
        checks++;
        if (data_o !== 32'h0) begin failures++; $display("FAIL reset_data: got %h expected 00000000", data_o); end
        arstn = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_basic();
        logic [31:0] exp_w;
        exp_w = pack4(8'h55, 8'hA3, 8'h00, 8'hFF);
        down_ready = 1'b0;
        send_frame(8'h55, 1'b1);
        send_frame(8'hA3, 1'b1);
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        checks++;
        if (down_valid !== 1'b1) begin failures++; $display("FAIL basic_valid: got %b expected 1", down_valid); end
        checks++;
        if (data_o !== exp_w) begin failures++; $display("FAIL basic_word: got %h expected %h", data_o, exp_w); end
        accept_word();
        checks++;
        if (down_valid !== 1'b0) begin failures++; $display("FAIL basic_handshake: valid got %b expected 0", down_valid); end
    endtask

    task automatic test_glitch();
        int fe0;
        int sb0;
        fe0 = fe_cnt;
        sb0 = sb_cnt;
        @(negedge clk);
        rx = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        repeat (3 * SCALE) @(negedge clk);
        checks++;
        if (sb_cnt !== sb0) begin failures++; $display("FAIL glitch_byte: strobes got %0d expected %0d", sb_cnt, sb0); end
        checks++;
        if (fe_cnt !== fe0) begin failures++; $display("FAIL glitch_frame_err: got %0d expected %0d", fe_cnt, fe0); end
        checks++;
        if (dut.u_reader.state !== IDLE) begin failures++; $display("FAIL glitch_state: got %0d expected %0d", dut.u_reader.state, IDLE); end
    endtask

    task automatic test_frame_err();
        int fe0;
        logic [7:0] r1, r2, r3;
        logic [31:0] exp_w;
        fe0 = fe_cnt;
        send_frame(8'h3C, 1'b0);
        checks++;
        if (fe_cnt !== fe0 + 1) begin failures++; $display("FAIL frame_err_pulse: got %0d expected %0d", fe_cnt - fe0, 1); end
        r1 = 8'($urandom);
        r2 = 8'($urandom);
        r3 = 8'($urandom);
        exp_w = pack4(8'h81, r1, r2, r3);
        send_frame(8'h81, 1'b1);
        send_frame(r1, 1'b1);
        send_frame(r2, 1'b1);
        send_frame(r3, 1'b1);
        checks++;
        if (data_o !== exp_w || down_valid !== 1'b1) begin
            failures++;
            $display("FAIL frame_err_next_word: got %h valid %b expected %h valid 1", data_o, down_valid, exp_w);
        end
        accept_word();
    endtask

    task automatic test_overrun();
        logic [7:0] b [5];
        logic [31:0] exp_w;
        int ov0;
        for (int i = 0; i < 5; i++) b[i] = 8'($urandom);
        exp_w = pack4(b[0], b[1], b[2], b[3]);
        down_ready = 1'b0;
        for (int i = 0; i < 4; i++) send_frame(b[i], 1'b1);
        ov0 = ov_cnt;
        send_frame(b[4], 1'b1);
        checks++;
        if (ov_cnt !== ov0 + 1) begin failures++; $display("FAIL overrun_pulse: got %0d expected 1", ov_cnt - ov0); end
        checks++;
        if (data_o !== exp_w) begin failures++; $display("FAIL overrun_word_stable: got %h expected %h", data_o, exp_w); end
        checks++;
        if (down_valid !== 1'b1) begin failures++; $display("FAIL overrun_valid_held: got %b expected 1", down_valid); end
        accept_word();
    endtask

    task automatic test_back_to_back();
        logic [7:0] b [4];
        logic [7:0] nb, r1, r2, r3;
        logic [31:0] exp_w;
        logic done;
        int ov0;
        for (int i = 0; i < 4; i++) b[i] = 8'($urandom);
        nb = 8'($urandom);
        down_ready = 1'b0;
        for (int i = 0; i < 4; i++) send_frame(b[i], 1'b1);
        exp_w = pack4(b[0], b[1], b[2], b[3]);
        checks++;
        if (data_o !== exp_w) begin failures++; $display("FAIL b2b_first_word: got %h expected %h", data_o, exp_w); end
        ov0 = ov_cnt;
        done = 1'b0;
        fork
            send_frame(nb, 1'b1);
            begin
                for (int i = 0; i < 300 && !done; i++) begin
                    @(negedge clk);
                    if (dut.byte_strobe) begin
                        down_ready = 1'b1;
                        @(negedge clk);
                        down_ready = 1'b0;
                        done = 1'b1;
                    end
                end
            end
        join
        checks++;
        if (done !== 1'b1) begin failures++; $display("FAIL b2b_strobe_timeout: got %b expected 1", done); end
        checks++;
        if (down_valid !== 1'b0) begin failures++; $display("FAIL b2b_valid_cleared: got %b expected 0", down_valid); end
        checks++;
        if (data_o[0] !== nb) begin failures++; $display("FAIL b2b_slot0: got %h expected %h", data_o[0], nb); end
        checks++;
        if (ov_cnt !== ov0) begin failures++; $display("FAIL b2b_no_overrun: got %0d expected 0", ov_cnt - ov0); end
        r1 = 8'($urandom);
        r2 = 8'($urandom);
        r3 = 8'($urandom);
        send_frame(r1, 1'b1);
        send_frame(r2, 1'b1);
        send_frame(r3, 1'b1);
        exp_w = pack4(nb, r1, r2, r3);
        checks++;
        if (data_o !== exp_w || down_valid !== 1'b1) begin
            failures++;
            $display("FAIL b2b_second_word: got %h valid %b expected %h valid 1", data_o, down_valid, exp_w);
        end
        accept_word();
    endtask

    task automatic test_loopback();
        logic [7:0] b [4];
        logic [31:0] exp_w;
        for (int w = 0; w < 3; w++) begin
            for (int i = 0; i < 4; i++) b[i] = 8'($urandom);
            exp_w = pack4(b[0], b[1], b[2], b[3]);
            for (int i = 0; i < 4; i++) send_frame(b[i], 1'b1);
            checks++;
            if (data_o !== exp_w || down_valid !== 1'b1) begin
                failures++;
                $display("FAIL loopback_word%0d: got %h valid %b expected %h valid 1", w, data_o, down_valid, exp_w);
            end
            accept_word();
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] b0, b1;
        logic [7:0] f [4];
        logic [31:0] exp_w;
        b0 = 8'($urandom);
        b1 = 8'($urandom);
        send_frame(b0, 1'b1);
        @(negedge clk);
        rx = 1'b0;
        repeat (SCALE) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            rx = b1[i];
            repeat (SCALE) @(negedge clk);
        end
        arstn = 1'b0;
        rx = 1'b1;
        @(negedge clk);
        checks++;
        if (down_valid !== 1'b0 || frame_err !== 1'b0 || overrun !== 1'b0) begin
            failures++;
            $display("FAIL midreset_flags: got valid %b fe %b ov %b expected 0 0 0", down_valid, frame_err, overrun);
        end
        checks++;
        if (data_o !== 32'h0) begin failures++; $display("FAIL midreset_data: got %h expected 00000000", data_o); end
        checks++;
        if (dut.u_reader.state !== IDLE) begin failures++; $display("FAIL midreset_state: got %0d expected %0d", dut.u_reader.state, IDLE); end
        repeat (2) @(negedge clk);
        arstn = 1'b1;
        repeat (2 * SCALE) @(negedge clk);
        for (int i = 0; i < 4; i++) f[i] = 8'($urandom);
        exp_w = pack4(f[0], f[1], f[2], f[3]);
        for (int i = 0; i < 4; i++) send_frame(f[i], 1'b1);
        checks++;
        if (data_o !== exp_w || down_valid !== 1'b1) begin
            failures++;
            $display("FAIL midreset_fresh_word: got %h valid %b expected %h valid 1", data_o, down_valid, exp_w);
        end
        accept_word();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_glitch();
        test_frame_err();
        test_overrun();
        test_back_to_back();
        test_loopback();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
